// File: rtl/rv_pkg.sv
// Shared core-wide widths and the write-back entry layout.
package rv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [CNT_W-1:0]      pend_cnt_t;

    localparam pend_cnt_t CNT_MAX = '1;

    typedef struct packed {
        reg_addr_t rd;
        xlen_t     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Power-of-two FIFO with synchronous push/pop; pushes while full and pops while empty are ignored.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/wb_unit.sv
// Write-back unit: arbitrates load/ALU results into a FIFO, drains one register-file
// write per cycle and tracks outstanding writes per register for decode stalls.
module wb_unit
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  stall,
    output logic                  wen,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [XLEN-1:0]       w_data
);
    logic                w_full;
    logic                w_empty;
    logic                w_ld_acc;
    logic                w_alu_acc;
    logic                w_push;
    logic                w_inc;
    wb_entry_t           w_push_entry;
    wb_entry_t           w_head;
    logic [NUM_REGS-1:0] w_inc_vec;
    logic [NUM_REGS-1:0] w_dec_vec;

    pend_cnt_t r_cnt [NUM_REGS];
    logic      r_wen;
    reg_addr_t r_w_addr;
    xlen_t     r_w_data;

    // Load wins arbitration; nothing is accepted while the FIFO is full or in reset.
    assign ld_ready  = !rst && !w_full;
    assign alu_ready = !rst && !w_full && !ld_valid;
    assign w_ld_acc  = ld_valid && ld_ready;
    assign w_alu_acc = alu_valid && alu_ready;

    always_comb begin
        w_push       = 1'b0;
        w_push_entry = '{rd: alu_rd, data: alu_data};
        if (w_ld_acc) begin
            w_push       = (ld_rd != '0);
            w_push_entry = '{rd: ld_rd, data: ld_data};
        end else if (w_alu_acc) begin
            w_push = (alu_rd != '0);
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(wb_entry_t))
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (!w_empty),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen    <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else if (!w_empty) begin
            r_wen    <= 1'b1;
            r_w_addr <= w_head.rd;
            r_w_data <= w_head.data;
        end else begin
            r_wen    <= 1'b0;
        end
    end

    assign wen    = r_wen;
    assign w_addr = r_w_addr;
    assign w_data = r_w_data;

    assign issue_ready = !rst && !((issue_rd != '0) && (r_cnt[issue_rd] == CNT_MAX));
    assign w_inc       = issue_valid && issue_ready && (issue_rd != '0);
    assign stall       = ((rs1 != '0) && (r_cnt[rs1] != '0)) ||
                         ((rs2 != '0) && (r_cnt[rs2] != '0));

    // A commit against a zero counter is dropped rather than wrapping to 3.
    always_comb begin
        w_inc_vec = '0;
        w_dec_vec = '0;
        if (w_inc) w_inc_vec[issue_rd] = 1'b1;
        if (r_wen && (r_cnt[r_w_addr] != '0)) w_dec_vec[r_w_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst || (i == 0)) begin
                r_cnt[i] <= '0;
            end else if (w_inc_vec[i] && !w_dec_vec[i]) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    // Every committed write must have been issued first.
    always_ff @(posedge clk) begin
        if (!rst && r_wen) begin
            assert (r_cnt[r_w_addr] != '0);
        end
    end
endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: scoreboard of expected register-file writes plus
// directed checks of latency, arbitration, pending counters, stall and reset.
module tb_wb_unit;
    import rv_pkg::*;

    localparam int SBW = REG_ADDR_W + XLEN;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_ready;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  stall;
    logic                  wen;
    logic [REG_ADDR_W-1:0] w_addr;
    logic [XLEN-1:0]       w_data;

    logic           f_push;
    logic           f_pop;
    logic [SBW-1:0] f_din;
    logic [SBW-1:0] f_dout;
    logic           f_full;
    logic           f_empty;

    int n_checks = 0;
    int n_fails  = 0;
    int n_writes = 0;
    int run_len  = 0;
    int max_run  = 0;
    logic [SBW-1:0] exp_q[$];
    logic [SBW-1:0] mon_e;

    always #5 clk = ~clk;

    wb_unit #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .rs1         (rs1),
        .rs2         (rs2),
        .stall       (stall),
        .wen         (wen),
        .w_addr      (w_addr),
        .w_data      (w_data)
    );

    // The top drains every cycle, so the full flag is exercised on a standalone FIFO.
    wb_fifo #(.DEPTH(4), .W(SBW)) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (f_push),
        .i_data  (f_din),
        .i_pop   (f_pop),
        .o_data  (f_dout),
        .o_full  (f_full),
        .o_empty (f_empty)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wen) begin
            n_writes++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 64'(wen), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_addr", 64'(w_addr), 64'(mon_e[SBW-1:XLEN]));
                check("wb_data", 64'(w_data), 64'(mon_e[XLEN-1:0]));
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0;
        alu_valid   = 1'b0;
        ld_valid    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            clear_inputs();
            sample();
        end
    endtask

    task automatic do_issue(input logic [REG_ADDR_W-1:0] rd, input logic exp_ready);
        step();
        clear_inputs();
        issue_valid = 1'b1;
        issue_rd    = rd;
        sample();
        check("issue_ready", 64'(issue_ready), 64'(exp_ready));
    endtask

    task automatic do_result(input logic is_ld, input logic [REG_ADDR_W-1:0] rd,
                             input logic [XLEN-1:0] d, input logic exp_ready);
        step();
        clear_inputs();
        if (is_ld) begin
            ld_valid = 1'b1;
            ld_rd    = rd;
            ld_data  = d;
        end else begin
            alu_valid = 1'b1;
            alu_rd    = rd;
            alu_data  = d;
        end
        sample();
        if (is_ld) check("ld_ready", 64'(ld_ready), 64'(exp_ready));
        else       check("alu_ready", 64'(alu_ready), 64'(exp_ready));
        if (exp_ready && rd != '0) exp_q.push_back({rd, d});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [SBW-1:0] fvals [4];

        rst = 1'b1;
        clear_inputs();
        issue_rd = '0; alu_rd = '0; alu_data = '0; ld_rd = '0; ld_data = '0;
        rs1 = '0; rs2 = '0;
        f_push = 1'b0; f_pop = 1'b0; f_din = '0;
        repeat (3) @(posedge clk);
        sample();
        check("rst_wen", 64'(wen), 64'(0));
        check("rst_w_addr", 64'(w_addr), 64'(0));
        check("rst_w_data", 64'(w_data), 64'(0));
        check("rst_ld_ready", 64'(ld_ready), 64'(0));
        check("rst_alu_ready", 64'(alu_ready), 64'(0));
        check("rst_issue_ready", 64'(issue_ready), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        step();
        rst = 1'b0;
        sample();
        check("post_rst_ld_ready", 64'(ld_ready), 64'(1));

        // Latency: result accepted at edge k shows wen after k+1, stall clears after k+2.
        do_issue(5'd5, 1'b1);
        rs1 = 5'd5;
        do_result(1'b0, 5'd5, 32'hDEADBEEF, 1'b1);
        check("lat_stall_pending", 64'(stall), 64'(1));
        idle(1);
        check("lat_wen_k", 64'(wen), 64'(0));
        idle(1);
        check("lat_wen_k1", 64'(wen), 64'(1));
        check("lat_stall_k1", 64'(stall), 64'(1));
        idle(1);
        check("lat_stall_k2", 64'(stall), 64'(0));

        // Load and ALU in the same cycle: load first, ALU retries.
        do_issue(5'd3, 1'b1);
        do_issue(5'd4, 1'b1);
        step();
        clear_inputs();
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hA5A5_0003;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h5A5A_0004;
        sample();
        check("arb_ld_ready", 64'(ld_ready), 64'(1));
        check("arb_alu_ready", 64'(alu_ready), 64'(0));
        exp_q.push_back({5'd3, 32'hA5A5_0003});
        do_result(1'b0, 5'd4, 32'h5A5A_0004, 1'b1);
        idle(4);
        rs1 = 5'd3; rs2 = 5'd4;
        #1;
        check("arb_stall_clear", 64'(stall), 64'(0));

        // Five back-to-back results drain one per cycle.
        for (int i = 0; i < 5; i++) do_issue(REG_ADDR_W'(10 + i), 1'b1);
        w0 = n_writes;
        max_run = 0;
        for (int i = 0; i < 5; i++) begin
            do_result(i[0], REG_ADDR_W'(10 + i), $urandom, 1'b1);
        end
        idle(4);
        check("burst_writes", 64'(n_writes - w0), 64'(5));
        check("burst_run", 64'(max_run), 64'(5));

        // FIFO fills to DEPTH with no drain; pushes while full are dropped.
        for (int i = 0; i < 4; i++) begin
            step();
            fvals[i] = {REG_ADDR_W'(i + 1), 32'($urandom)};
            f_push = 1'b1;
            f_din  = fvals[i];
            sample();
            check("fifo_not_full", 64'(f_full), 64'(0));
        end
        step();
        f_din = '1;
        sample();
        check("fifo_full", 64'(f_full), 64'(1));
        check("fifo_not_empty", 64'(f_empty), 64'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            f_push = 1'b0;
            f_pop  = 1'b1;
            sample();
            check("fifo_order", 64'(f_dout), 64'(fvals[i]));
        end
        step();
        f_pop = 1'b0;
        sample();
        check("fifo_empty", 64'(f_empty), 64'(1));

        // rd==0 result is accepted and dropped.
        rs1 = 5'd5; rs2 = 5'd0;
        w0 = n_writes;
        do_result(1'b0, 5'd0, 32'h0000_1234, 1'b1);
        check("rd0_stall", 64'(stall), 64'(0));
        idle(3);
        check("rd0_no_write", 64'(n_writes - w0), 64'(0));
        check("rd0_stall_after", 64'(stall), 64'(0));

        // Saturating pending counter on rd=7.
        for (int i = 0; i < 3; i++) do_issue(5'd7, 1'b1);
        step();
        clear_inputs();
        issue_rd = 5'd7;
        sample();
        check("cnt7_sat_ready", 64'(issue_ready), 64'(0));
        issue_rd = 5'd8;
        #1;
        check("cnt8_ready", 64'(issue_ready), 64'(1));
        do_result(1'b0, 5'd7, 32'h7777_0001, 1'b1);
        idle(1);
        step();
        clear_inputs();
        issue_valid = 1'b1; issue_rd = 5'd7;
        sample();
        check("cnt7_commit_wen", 64'(wen), 64'(1));
        check("cnt7_refused", 64'(issue_ready), 64'(0));
        step();
        sample();
        check("cnt7_reopen", 64'(issue_ready), 64'(1));
        step();
        clear_inputs();
        issue_rd = 5'd7;
        sample();
        check("cnt7_back_to_3", 64'(issue_ready), 64'(0));
        for (int i = 0; i < 3; i++) do_result(1'b1, 5'd7, $urandom, 1'b1);
        idle(4);
        rs1 = 5'd7; rs2 = 5'd0;
        #1;
        check("cnt7_drained", 64'(stall), 64'(0));

        // Increment and commit on the same edge cancel.
        do_issue(5'd9, 1'b1);
        do_result(1'b0, 5'd9, 32'h9999_0001, 1'b1);
        idle(1);
        step();
        clear_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9;
        sample();
        check("same_edge_ready", 64'(issue_ready), 64'(1));
        step();
        clear_inputs();
        rs1 = 5'd9;
        sample();
        check("same_edge_stall", 64'(stall), 64'(1));
        do_result(1'b0, 5'd9, 32'h9999_0002, 1'b1);
        idle(4);
        check("same_edge_drained", 64'(stall), 64'(0));

        // Reset with results in flight.
        do_issue(5'd20, 1'b1);
        do_issue(5'd21, 1'b1);
        do_issue(5'd22, 1'b1);
        do_result(1'b1, 5'd20, 32'h2020_2020, 1'b1);
        do_result(1'b0, 5'd21, 32'h2121_2121, 1'b1);
        do_result(1'b0, 5'd22, 32'h2222_2222, 1'b1);
        step();
        clear_inputs();
        rs1 = 5'd21; rs2 = 5'd22;
        rst = 1'b1;
        sample();
        check("mid_rst_stall_pre", 64'(stall), 64'(1));
        check("mid_rst_ld_ready", 64'(ld_ready), 64'(0));
        check("mid_rst_alu_ready", 64'(alu_ready), 64'(0));
        step();
        exp_q.delete();
        sample();
        check("mid_rst_wen", 64'(wen), 64'(0));
        check("mid_rst_w_addr", 64'(w_addr), 64'(0));
        check("mid_rst_w_data", 64'(w_data), 64'(0));
        check("mid_rst_stall", 64'(stall), 64'(0));
        step();
        rst = 1'b0;
        rs1 = 5'd20; rs2 = 5'd0;
        issue_rd = 5'd22;
        sample();
        check("post_rst_wen", 64'(wen), 64'(0));
        check("post_rst_stall", 64'(stall), 64'(0));
        check("post_rst_issue_ready", 64'(issue_ready), 64'(1));
        idle(3);
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter: DEPTH, 4, write-back FIFO entries (power of two, >=2).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: issue_valid  in  1  instruction with destination issued this cycle.
REQ-005 SHALL have port: issue_rd  in  5  destination register of the issuing instruction.
REQ-006 SHALL have port: issue_ready  out  1  issue may be accepted.
REQ-007 SHALL have port: alu_valid / alu_ready / alu_rd / alu_data  in/out/in/in  1/1/5/32  ALU result handshake.
REQ-008 SHALL have port: ld_valid / ld_ready / ld_rd / ld_data  in/out/in/in  1/1/5/32  load result handshake.
REQ-009 SHALL have port: rs1, rs2  in  5  decode source-register query.
REQ-010 SHALL have port: stall  out  1  rs1 or rs2 has an outstanding write.
REQ-011 SHALL have port: wen / w_addr / w_data  out  1/5/32  register-file write port, registered.

Function
REQ-012 SHALL transfer a source when valid and ready are both high at a rising edge.
REQ-013 SHALL accept at most one result per cycle; load has priority: ld_ready = !full; alu_ready = !full && !ld_valid.
REQ-014 SHALL discard an accepted result with rd==0 (no enqueue, no wen, no counter change).
REQ-015 SHALL enqueue accepted results with rd!=0 in acceptance order.
REQ-016 SHALL pop the FIFO head into wen/w_addr/w_data at each edge where the FIFO is non-empty; otherwise wen<=0, w_addr and w_data hold.
REQ-017 SHALL give latency: result accepted at edge k into an empty FIFO -> wen=1 during cycle after edge k+1; register file commits at edge k+2.
REQ-018 SHALL sustain one write per cycle; full = DEPTH entries stored; simultaneous push and pop when full is not permitted (ready low while full).
REQ-019 SHALL keep a 2-bit pending counter per register 1..31; register 0 has none and is never pending.
REQ-020 SHALL increment cnt[issue_rd] on issue_valid && issue_ready && issue_rd!=0.
REQ-021 SHALL decrement cnt[w_addr] at each edge where wen=1 (commit edge).
REQ-022 SHALL leave a counter unchanged when increment and decrement hit it on the same edge.
REQ-023 SHALL drive issue_ready = 0 when issue_rd!=0 and cnt[issue_rd]==3; else 1.
REQ-024 SHALL drive stall combinationally: (rs1!=0 && cnt[rs1]!=0) || (rs2!=0 && cnt[rs2]!=0).
REQ-025 SHALL not underflow a counter; a commit to a zero counter leaves it at 0 (protocol error, flagged by assertion).

Reset
REQ-026 SHALL, on rst high at an edge: FIFO empty, all counters 0, wen=0, w_addr=0, w_data=0.
REQ-027 SHALL discard all in-flight results on reset mid-operation; no wen in the cycle after the reset edge.
REQ-028 SHALL hold ready outputs low while rst is high.

Structure
REQ-029 SHALL take XLEN=32, REG_ADDR_W=5, NUM_REGS=32 from shared package rv_pkg.
REQ-030 SHALL implement the FIFO as sub-module wb_fifo (parameter DEPTH, synchronous push/pop, full/empty flags).
REQ-031 SHALL keep arbitration, counters and output register in wb_unit.

Verification
REQ-032 SHALL test: issue rd=5, ALU result rd=5 data 0xDEADBEEF at edge k -> wen=1, w_addr=5, w_data=0xDEADBEEF after edge k+1; stall for rs1=5 clears after edge k+2.
REQ-033 SHALL test: ld_valid and alu_valid same cycle (rd 3 / rd 4) -> load accepted first, alu_ready=0; writes commit in order 3 then 4.
REQ-034 SHALL test: 5 back-to-back results with rf draining -> no loss, writes emitted in order, one per cycle; fill 4 with drain blocked by timing -> ready=0 when full.
REQ-035 SHALL test: ALU result rd=0 data 0x1234 -> accepted, no wen, stall unaffected.
REQ-036 SHALL test: three issues to rd=7 -> issue_ready=0 for rd=7; commit and fourth issue on same edge -> counter stays 3.
REQ-037 SHALL test: rst at edge with 3 entries queued -> wen=0 next cycle, stall=0, counters 0.
